bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
- REQ-001: Parameter W_BIN, default 16: width of the binary input, legal range 4..32.
- REQ-002: Parameter N_DIG, default 5: number of BCD output digits, legal range 1..10.
- REQ-003: clk  input  1  single clock; all state updates on the rising edge.
- REQ-004: rst  input  1  reset, asynchronous and active-high.
- REQ-005: start  input  1  conversion request; sampled on a clk edge when busy=0.
- REQ-006: num_bin  input  W_BIN  binary operand; captured on the accepting edge.
- REQ-007: busy  output  1  high while a conversion is in progress.
- REQ-008: done  output  1  single-cycle pulse marking a new result.
- REQ-009: num_BCD  output  4*N_DIG  result, packed BCD with digit 0 in bits [3:0].
- REQ-010: ovf  output  1  result magnitude does not fit in N_DIG digits.
- REQ-011: neg  output  1  result sign; the port always exists, its behaviour is set per REQ-028.

Function
- REQ-012: The conversion algorithm SHALL be sequential double dabble: one input bit per cycle, with add-3 applied to every digit ≥5 before each shift.
- REQ-013: The FSM SHALL have three states:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1.
  - DONE: busy=0, done=1, lasting one cycle.
- REQ-014: In IDLE or DONE, start=1 on a clk edge SHALL capture num_bin and enter SHIFT.
- REQ-015: While busy=1, start SHALL be ignored, and num_bin changes SHALL NOT affect the conversion in progress.
- REQ-016: SHIFT SHALL last exactly W_BIN cycles, counted by an internal counter of width ceil(log2(W_BIN+1)).
  - The counter SHALL reach its terminal count and then transition to DONE.
- REQ-017: Latency SHALL be fixed: for a start accepted at edge t0, done=1 in the cycle following edge t0+W_BIN.
  - In that same cycle, num_BCD, ovf and neg SHALL present the new result.
- REQ-018: DONE SHALL return to IDLE after one cycle, unless start=1 on that edge.
  - If start=1, the FSM SHALL go directly to SHIFT (back-to-back conversions, period W_BIN+1 cycles).
- REQ-019: num_BCD, ovf and neg SHALL be registered outputs.
  - They SHALL update only on the edge entering DONE.
  - They SHALL hold their value until the next completion or until reset.
- REQ-020: The internal scratch register SHALL carry enough guard digits that no input value is ever lost.
- REQ-021: ovf SHALL be 1 if and only if the magnitude is ≥ 10^N_DIG.
  - In that case num_BCD SHALL hold the N_DIG least-significant decimal digits of the magnitude.
- REQ-022: Zero input SHALL produce num_BCD=0, ovf=0 and neg=0.
- REQ-023: Every output nibble of num_BCD SHALL be within 0..9 under all conditions.

Reset
- REQ-024: rst=1 SHALL immediately force IDLE, independent of clk.
  - Outputs SHALL be busy=0, done=0, num_BCD=0, ovf=0, neg=0.
  - The bit counter and scratch register SHALL be cleared.
- REQ-025: Asserting rst during SHIFT SHALL abort the conversion; done SHALL NOT be produced for the aborted request.
- REQ-026: After rst deasserts, the first rising clk edge with start=1 SHALL be accepted normally.

Configuration
- REQ-027: Macro BCD_SIGNED_EN selects signed operation.
- REQ-028: With BCD_SIGNED_EN defined:
  - num_bin SHALL be treated as two's complement.
  - The magnitude SHALL be converted, and neg SHALL equal the input MSB.
  - The most-negative input SHALL convert to its full magnitude (e.g. 32768 for W_BIN=16).
  - Latency SHALL be unchanged.
- REQ-029: Without BCD_SIGNED_EN:
  - num_bin SHALL be treated as unsigned.
  - neg SHALL be tied to 0.
  - No negation logic SHALL be synthesised.

Verification
- REQ-030: W_BIN=16, N_DIG=5, unsigned.
  - Stimulus: start with num_bin=9999.
  - Required: busy=1 for 16 cycles, then done pulses once with num_BCD=0x09999 and ovf=0.
  - Stimulus: start with num_bin=65535.
  - Required: num_BCD=0x65535.
- REQ-031: W_BIN=16, N_DIG=4.
  - Stimulus: num_bin=12345.
  - Required: ovf=1, num_BCD=0x2345.
  - Stimulus: num_bin=9999.
  - Required: ovf=0, num_BCD=0x9999.
- REQ-032: Stimulus: start held high continuously, with num_bin changing every cycle.
  - Required: conversions every 17 cycles.
  - Required: each result matches the num_bin value at its accepting edge, with mid-conversion changes ignored.
- REQ-033: Stimulus: rst asserted asynchronously at cycle 8 of SHIFT.
  - Required: busy, done, num_BCD and ovf are 0 immediately, with no done pulse afterwards.
  - Stimulus: a following start with num_bin=123.
  - Required: num_BCD=0x00123.
- REQ-034: With BCD_SIGNED_EN defined:
  - num_bin=0xFB2E (-1234) → neg=1, num_BCD=0x01234.
  - num_bin=0x8000 → neg=1, num_BCD=0x32768.
  - num_bin=0 → neg=0, num_BCD=0.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to packed BCD converter
//
// Converts a W_BIN-bit binary operand to N_DIG packed BCD digits, one input
// bit per clock. A conversion takes W_BIN cycles in SHIFT, followed by a
// one-cycle DONE that may start the next conversion immediately.
//
// Parameters:
//   W_BIN    binary operand width (4..32)
//   N_DIG    number of BCD output digits (1..10)
// Optional feature:
//   BCD_SIGNED_EN  when defined, num_bin is two's complement; the magnitude
//                  is converted and neg reports the operand sign.
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   start    conversion request, accepted when busy=0
//   num_bin  binary operand, captured on the accepting edge
//   busy     conversion in progress
//   done     one-cycle pulse with a new result
//   num_BCD  result, digit 0 in bits [3:0]
//   ovf      magnitude >= 10**N_DIG (num_BCD keeps the low N_DIG digits)
//   neg      result sign (constant 0 in unsigned builds)

module bin_to_bcd_seq #(
  parameter int W_BIN = 16,
  parameter int N_DIG = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [W_BIN-1:0]   num_bin,
  output logic               busy,
  output logic               done,
  output logic [4*N_DIG-1:0] num_BCD,
  output logic               ovf,
  output logic               neg
);

  // Decimal digits needed for any W_BIN-bit magnitude (exact for W_BIN <= 32).
  localparam int N_FIT = (W_BIN * 3) / 10 + 1;
  // Scratch always carries at least one digit above the output so the
  // overflow test is a plain OR of the upper digits.
  localparam int N_SCR = (N_FIT > N_DIG) ? N_FIT : N_DIG + 1;
  localparam int CW    = $clog2(W_BIN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [W_BIN-1:0]   sh;
  logic [4*N_SCR-1:0] scr;
  logic [4*N_SCR-1:0] scr_adj;
  logic [4*N_SCR-1:0] scr_next;
  logic [W_BIN-1:0]   mag;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the
  // next operand bit (MSB first).
  always_comb begin
    scr_adj = scr;
    for (int i = 0; i < N_SCR; i++) begin
      if (scr[4*i +: 4] >= 4'd5)
        scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
    end
    scr_next = (scr_adj << 1) | {{(4*N_SCR-1){1'b0}}, sh[W_BIN-1]};
  end

`ifdef BCD_SIGNED_EN
  logic sign;

  // The most-negative operand negates to itself, which read as unsigned is
  // exactly its magnitude.
  assign mag = num_bin[W_BIN-1] ? (~num_bin + W_BIN'(1)) : num_bin;
`else
  assign mag = num_bin;
  assign neg = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      scr     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      num_BCD <= '0;
      ovf     <= 1'b0;
`ifdef BCD_SIGNED_EN
      sign    <= 1'b0;
      neg     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            cnt   <= '0;
            sh    <= mag;
            scr   <= '0;
`ifdef BCD_SIGNED_EN
            sign  <= num_bin[W_BIN-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          scr <= scr_next;
          sh  <= sh << 1;
          cnt <= cnt + CW'(1);
          // The last shift result goes straight to the output registers.
          if (cnt == CW'(W_BIN - 1)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            num_BCD <= scr_next[4*N_DIG-1:0];
            ovf     <= |scr_next[4*N_SCR-1:4*N_DIG];
`ifdef BCD_SIGNED_EN
            neg     <= sign;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed self-checking bench for bin_to_bcd_seq
//
// Two instances share all inputs: dut5 (N_DIG=5) and dut4 (N_DIG=4, for
// overflow behaviour). Inputs change and outputs are sampled on the falling
// clock edge.

module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_bin;

  logic        busy5, done5, ovf5, neg5;
  logic [19:0] bcd5;
  logic        busy4, done4, ovf4, neg4;
  logic [15:0] bcd4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.W_BIN(16), .N_DIG(5)) dut5 (
    .clk(clk), .rst(rst), .start(start), .num_bin(num_bin),
    .busy(busy5), .done(done5), .num_BCD(bcd5), .ovf(ovf5), .neg(neg5)
  );

  bin_to_bcd_seq #(.W_BIN(16), .N_DIG(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .num_bin(num_bin),
    .busy(busy4), .done(done4), .num_BCD(bcd4), .ovf(ovf4), .neg(neg4)
  );

  // Request a conversion; the operand is scrambled right after acceptance.
  task automatic start_conv(input logic [15:0] v);
    @(negedge clk);
    start   = 1'b1;
    num_bin = v;
    @(negedge clk);
    start   = 1'b0;
    num_bin = 16'hA5A5;
  endtask

  // Bounded wait for done5; counts busy cycles seen on the way.
  task automatic wait_done(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (done5) begin
        seen = 1'b1;
        break;
      end
      if (busy5) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    start   = 1'b0;
    num_bin = 16'h0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy5, done5, ovf5, neg5, bcd5} !== 24'h0) begin
      $display("FAIL reset_dut5: got busy=%b done=%b ovf=%b neg=%b bcd=%h want all 0",
               busy5, done5, ovf5, neg5, bcd5);
      n_fail++;
    end
    n_cmp++;
    if ({busy4, done4, ovf4, neg4, bcd4} !== 20'h0) begin
      $display("FAIL reset_dut4: got busy=%b done=%b ovf=%b neg=%b bcd=%h want all 0",
               busy4, done4, ovf4, neg4, bcd4);
      n_fail++;
    end
    rst = 1'b0;
  endtask

  task automatic run_vector(input logic [15:0] v,
                            input logic [19:0] e5, input logic eovf5,
                            input logic [15:0] e4, input logic eovf4,
                            input logic eneg);
    int nbusy;
    bit seen;
    start_conv(v);
    wait_done(nbusy, seen);
    n_cmp++;
    if (!seen) begin
      $display("FAIL done_timeout[%h]: got no done want done within bound", v);
      n_fail++;
    end
    n_cmp++;
    if (nbusy != 16) begin
      $display("FAIL busy_cycles[%h]: got %0d want 16", v, nbusy);
      n_fail++;
    end
    n_cmp++;
    if (bcd5 !== e5 || ovf5 !== eovf5 || neg5 !== eneg) begin
      $display("FAIL result5[%h]: got bcd=%h ovf=%b neg=%b want bcd=%h ovf=%b neg=%b",
               v, bcd5, ovf5, neg5, e5, eovf5, eneg);
      n_fail++;
    end
    n_cmp++;
    if (done4 !== 1'b1 || bcd4 !== e4 || ovf4 !== eovf4) begin
      $display("FAIL result4[%h]: got done=%b bcd=%h ovf=%b want done=1 bcd=%h ovf=%b",
               v, done4, bcd4, ovf4, e4, eovf4);
      n_fail++;
    end
    @(negedge clk);
    n_cmp++;
    if (done5 !== 1'b0 || busy5 !== 1'b0) begin
      $display("FAIL done_pulse[%h]: got done=%b busy=%b want done=0 busy=0",
               v, done5, busy5);
      n_fail++;
    end
  endtask

  task automatic test_values;
`ifdef BCD_SIGNED_EN
    run_vector(16'hFB2E, 20'h01234, 1'b0, 16'h1234, 1'b0, 1'b1);
    run_vector(16'h8000, 20'h32768, 1'b0, 16'h2768, 1'b1, 1'b1);
    run_vector(16'h0000, 20'h00000, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_vector(16'd9999, 20'h09999, 1'b0, 16'h9999, 1'b0, 1'b0);
    run_vector(16'd12345, 20'h12345, 1'b0, 16'h2345, 1'b1, 1'b0);
    run_vector(16'hFFFF, 20'h00001, 1'b0, 16'h0001, 1'b0, 1'b1);
`else
    run_vector(16'd9999, 20'h09999, 1'b0, 16'h9999, 1'b0, 1'b0);
    run_vector(16'd65535, 20'h65535, 1'b0, 16'h5535, 1'b1, 1'b0);
    run_vector(16'd12345, 20'h12345, 1'b0, 16'h2345, 1'b1, 1'b0);
    run_vector(16'd0, 20'h00000, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_vector(16'd10000, 20'h10000, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_vector(16'hFB2E, 20'h64302, 1'b0, 16'h4302, 1'b1, 1'b0);
    run_vector(16'h8000, 20'h32768, 1'b0, 16'h2768, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_hold;
    int nbusy;
    bit seen;
    start_conv(16'd2024);
    wait_done(nbusy, seen);
    n_cmp++;
    if (!seen) begin
      $display("FAIL hold_done: got no done want done within bound");
      n_fail++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      num_bin = 16'(k * 777 + 1);
      n_cmp++;
      if (bcd5 !== 20'h02024 || done5 !== 1'b0 || busy5 !== 1'b0) begin
        $display("FAIL hold[%0d]: got bcd=%h done=%b busy=%b want bcd=02024 done=0 busy=0",
                 k, bcd5, done5, busy5);
        n_fail++;
      end
    end
  endtask

  // start held high, operand n*500+5 at falling edge n: accepts at n=0,17,34.
  task automatic test_back_to_back;
    logic [19:0] exp_tbl [3];
    int ndone;
    exp_tbl[0] = 20'h00005;
    exp_tbl[1] = 20'h08505;
    exp_tbl[2] = 20'h17005;
    ndone = 0;
    @(negedge clk);
    for (int n = 0; n <= 51; n++) begin
      if (n > 0) begin
        n_cmp++;
        if (done5 !== (n % 17 == 0) || busy5 !== (n % 17 != 0)) begin
          $display("FAIL b2b_ctrl[%0d]: got done=%b busy=%b want done=%b busy=%b",
                   n, done5, busy5, (n % 17 == 0), (n % 17 != 0));
          n_fail++;
        end
        if (n % 17 == 0) begin
          ndone++;
          n_cmp++;
          if (bcd5 !== exp_tbl[n/17 - 1]) begin
            $display("FAIL b2b_result[%0d]: got %h want %h", n, bcd5, exp_tbl[n/17 - 1]);
            n_fail++;
          end
        end
      end
      num_bin = 16'(n * 500 + 5);
      start   = (n < 51);
      @(negedge clk);
    end
    n_cmp++;
    if (ndone != 3) begin
      $display("FAIL b2b_count: got %0d want 3", ndone);
      n_fail++;
    end
  endtask

  task automatic test_abort;
    int nbusy;
    bit seen;
    int spurious;
    start_conv(16'd4321);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (busy5 !== 1'b0 || done5 !== 1'b0 || bcd5 !== 20'h0 || ovf5 !== 1'b0) begin
      $display("FAIL abort_async: got busy=%b done=%b bcd=%h ovf=%b want all 0",
               busy5, done5, bcd5, ovf5);
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done5 || busy5) spurious++;
    end
    n_cmp++;
    if (spurious != 0) begin
      $display("FAIL abort_no_done: got %0d active cycles want 0", spurious);
      n_fail++;
    end
    start_conv(16'd123);
    wait_done(nbusy, seen);
    n_cmp++;
    if (!seen || bcd5 !== 20'h00123 || ovf5 !== 1'b0) begin
      $display("FAIL after_abort: got seen=%b bcd=%h ovf=%b want seen=1 bcd=00123 ovf=0",
               seen, bcd5, ovf5);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_hold();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
